alu_writeback_stage: RTL and testbench
======================================

// Module: alu_writeback_stage
// PURPOSE
//  Execute-to-writeback buffer directly downstream of the ALU. Captures each ALU result with its
//  NEG/ZERO flags, destination register and write/flag controls into a 2-entry in-order skid
//  buffer. Presents the entries to the register-file write port over a valid/ready handshake and
//  maintains the architectural N/Z condition-flag register used by branches.
// PARAMETERS
//  DATA_W  32  result width; must match the ALU result width
//  REG_AW  5   register address width; register 0 is hardwired zero
// PORTS
//  iClk       in   1       clock; all state updates on rising edge
//  iRst_n     in   1       asynchronous active-low reset
//  iValid     in   1       upstream ALU result valid
//  oReady     out  1       stage can accept (registered, = !full)
//  iResult    in   DATA_W  ALU result
//  iNEG       in   1       ALU negative flag for iResult
//  iZERO      in   1       ALU zero flag for iResult
//  iRd        in   REG_AW  destination register
//  iWrEn      in   1       result is written to iRd
//  iSetFlags  in   1       result updates architectural N/Z
//  oWbValid   out  1       head entry valid
//  iWbReady   in   1       register file accepts head
//  oWbData    out  DATA_W  head result
//  oWbRd      out  REG_AW  head destination
//  oWbWrEn    out  1       head write enable (0 if head rd==0)
//  oFlagN     out  1       architectural negative flag
//  oFlagZ     out  1       architectural zero flag
// BEHAVIOUR
//  - Reset (iRst_n low, async): count=0, oReady=1, oWbValid=0, oWbData=0, oWbRd=0,
//    oWbWrEn=0, oFlagN=0, oFlagZ=0. Reset mid-transfer discards all entries; no write escapes.
//  - Storage: 2 entries, in-order FIFO with wrapping 1-bit rd/wr pointers; count 0..2.
//  - Accept = iValid & oReady. Retire = oWbValid & iWbReady. oWbValid = (count != 0).
//  - Latency: an entry accepted at edge N is presented on oWb* after edge N (1 cycle); with
//    continuous iWbReady=1, throughput is 1 entry/cycle and count never exceeds 1.
//  - oReady is registered: next oReady = (next count < 2). When full, oReady=0 even if a retire
//    occurs in the same cycle; oReady returns to 1 on the following cycle.
//  - Simultaneous accept and retire: count unchanged; head advances, new entry at tail.
//  - iValid while oReady=0: ignored; upstream holds its data.
//  - iWrEn with iRd==0: stored WrEn forced to 0; entry still retires and may still set flags.
//  - Flags: on retire of an entry with SetFlags=1, oFlagN<=its NEG, oFlagZ<=its ZERO the same
//    edge. Entries without SetFlags leave the flags untouched. Flags change only at retire
//    (in order), never at accept.
//  - oWb* are held stable while oWbValid=1 and iWbReady=0.
//  - oWbData/oWbRd hold their last value when empty; oWbWrEn=0 when empty.
// CONFIGURATION
//  Macro WB_FWD_EN:
//  - Defined: adds inputs iSrcA and iSrcB [REG_AW] and outputs oFwdHitA, oFwdHitB [1] and
//    oFwdDataA, oFwdDataB [DATA_W]. These are combinational bypass ports for the operand stage.
//    A hit requires a valid entry with WrEn=1 and Rd==Src. The youngest matching entry supplies
//    the data. Src==0 never hits. With no hit, oFwdData=0.
//  - Undefined: those ports do not exist. No bypass logic is built.
// TESTING
//  1. Reset, then push {Res=0x0000_0005, Rd=3, WrEn=1, SetFlags=1, N=0, Z=0} with iWbReady=1
//     -> next cycle oWbValid=1, oWbData=5, oWbRd=3, oWbWrEn=1. Flags N=0, Z=0 after retire.
//  2. Hold iWbReady=0 and push 3 entries back-to-back -> oReady drops to 0 after the 2nd accept;
//     the 3rd is held. Then raise iWbReady -> entries retire in order, oReady=1 one cycle after
//     the first retire.
//  3. Push {Res=0xFFFF_FFFF, N=1, SetFlags=1} then {Res=0, Z=1, SetFlags=0} -> after both retire,
//     oFlagN=1 and oFlagZ=0.
//  4. Push Rd=0 with WrEn=1 and Res=0x1234 -> oWbWrEn=0 at retire. Assert iRst_n low while 2
//     entries are held -> oWbValid=0 and oReady=1 immediately.
//  5. (WB_FWD_EN) Hold entries Rd=7 with 0xA and, younger, Rd=7 with 0xB. Set iSrcA=7 and
//     iSrcB=0 -> oFwdHitA=1, oFwdDataA=0xB, oFwdHitB=0.

Source files
------------

// File: rtl/alu_writeback_stage.sv
// ALU-to-writeback 2-entry in-order skid buffer with architectural N/Z flags; 1-cycle latency, registered oReady (=!full).
// Optional bypass ports are built when WB_FWD_EN is defined.
module alu_writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iResult,
  input  logic              iNEG,
  input  logic              iZERO,
  input  logic [REG_AW-1:0] iRd,
  input  logic              iWrEn,
  input  logic              iSetFlags,
  output logic              oWbValid,
  input  logic              iWbReady,
  output logic [DATA_W-1:0] oWbData,
  output logic [REG_AW-1:0] oWbRd,
  output logic              oWbWrEn,
  output logic              oFlagN,
  output logic              oFlagZ
`ifdef WB_FWD_EN
  ,
  input  logic [REG_AW-1:0] iSrcA,
  input  logic [REG_AW-1:0] iSrcB,
  output logic              oFwdHitA,
  output logic              oFwdHitB,
  output logic [DATA_W-1:0] oFwdDataA,
  output logic [DATA_W-1:0] oFwdDataB
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] rd;
    logic              wren;
    logic              setf;
    logic              neg;
    logic              zero;
  } entry_t;

  entry_t            mem_q [2];
  entry_t            mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              ready_q, ready_d;
  logic              flag_n_q, flag_n_d;
  logic              flag_z_q, flag_z_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;

  logic   accept;
  logic   retire;
  entry_t head;
  entry_t new_entry;

  assign accept = iValid & ready_q;
  assign retire = (count_q != 2'd0) & iWbReady;
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    new_entry      = '0;
    new_entry.data = iResult;
    new_entry.rd   = iRd;
    // Register 0 is hardwired zero, so a write to it is dropped at capture.
    new_entry.wren = iWrEn & (iRd != '0);
    new_entry.setf = iSetFlags;
    new_entry.neg  = iNEG;
    new_entry.zero = iZERO;
  end

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (accept) begin
      mem_d[wr_ptr_q] = new_entry;
    end
    wr_ptr_d = wr_ptr_q ^ accept;
    rd_ptr_d = rd_ptr_q ^ retire;
    case ({accept, retire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    ready_d  = (count_d != 2'd2);
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    if (retire && head.setf) begin
      flag_n_d = head.neg;
      flag_z_d = head.zero;
    end
    // Presentation registers track the next head and hold their value once empty.
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    if (count_d != 2'd0) begin
      wb_data_d = mem_d[rd_ptr_d].data;
      wb_rd_d   = mem_d[rd_ptr_d].rd;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      ready_q   <= 1'b1;
      flag_n_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
    end else begin
      mem_q[0]  <= mem_d[0];
      mem_q[1]  <= mem_d[1];
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      flag_n_q  <= flag_n_d;
      flag_z_q  <= flag_z_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
    end
  end

  assign oReady   = ready_q;
  assign oWbValid = (count_q != 2'd0);
  assign oWbData  = wb_data_q;
  assign oWbRd    = wb_rd_q;
  assign oWbWrEn  = oWbValid & head.wren;
  assign oFlagN   = flag_n_q;
  assign oFlagZ   = flag_z_q;

`ifdef WB_FWD_EN
  // The slot behind the write pointer always holds the youngest live entry.
  logic yng_ptr;
  assign yng_ptr = ~wr_ptr_q;

  function automatic logic [DATA_W:0] fwd_lookup(input logic [REG_AW-1:0] src);
    entry_t yng;
    entry_t old;
    yng = mem_q[yng_ptr];
    old = mem_q[wr_ptr_q];
    if (src == '0) begin
      return '0;
    end else if ((count_q != 2'd0) && yng.wren && (yng.rd == src)) begin
      return {1'b1, yng.data};
    end else if ((count_q == 2'd2) && old.wren && (old.rd == src)) begin
      return {1'b1, old.data};
    end
    return '0;
  endfunction

  logic [DATA_W:0] fwd_a;
  logic [DATA_W:0] fwd_b;
  assign fwd_a     = fwd_lookup(iSrcA);
  assign fwd_b     = fwd_lookup(iSrcB);
  assign oFwdHitA  = fwd_a[DATA_W];
  assign oFwdHitB  = fwd_b[DATA_W];
  assign oFwdDataA = fwd_a[DATA_W-1:0];
  assign oFwdDataB = fwd_b[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: directed scenarios followed by randomized traffic.
module tb_alu_writeback_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          iValid = 1'b0;
  logic          oReady;
  logic [DW-1:0] iResult = '0;
  logic          iNEG = 1'b0;
  logic          iZERO = 1'b0;
  logic [AW-1:0] iRd = '0;
  logic          iWrEn = 1'b0;
  logic          iSetFlags = 1'b0;
  logic          oWbValid;
  logic          iWbReady = 1'b0;
  logic [DW-1:0] oWbData;
  logic [AW-1:0] oWbRd;
  logic          oWbWrEn;
  logic          oFlagN;
  logic          oFlagZ;
`ifdef WB_FWD_EN
  logic [AW-1:0] iSrcA = '0;
  logic [AW-1:0] iSrcB = '0;
  logic          oFwdHitA, oFwdHitB;
  logic [DW-1:0] oFwdDataA, oFwdDataB;
`endif

  always #5 clk = ~clk;

  alu_writeback_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
    .iClk(clk), .iRst_n(rst_n), .iValid(iValid), .oReady(oReady),
    .iResult(iResult), .iNEG(iNEG), .iZERO(iZERO), .iRd(iRd),
    .iWrEn(iWrEn), .iSetFlags(iSetFlags), .oWbValid(oWbValid),
    .iWbReady(iWbReady), .oWbData(oWbData), .oWbRd(oWbRd),
    .oWbWrEn(oWbWrEn), .oFlagN(oFlagN), .oFlagZ(oFlagZ)
`ifdef WB_FWD_EN
    , .iSrcA(iSrcA), .iSrcB(iSrcB), .oFwdHitA(oFwdHitA), .oFwdHitB(oFwdHitB),
    .oFwdDataA(oFwdDataA), .oFwdDataB(oFwdDataB)
`endif
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] rd;
    logic          wr;
    logic          sf;
    logic          n;
    logic          z;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          pend;
  logic          pend_v = 1'b0;
  logic          in_rst = 1'b1;
  logic          mdl_n = 1'b0, mdl_z = 1'b0;
  logic [DW-1:0] last_d = '0;
  logic [AW-1:0] last_rd = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef WB_FWD_EN
  // Youngest matching live entry wins: scan oldest to youngest, keep the last hit.
  function automatic logic [DW:0] fwd_model(input logic [AW-1:0] src);
    logic [DW:0] r;
    r = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (src != '0 && exp_q[i].wr && exp_q[i].rd == src) r = {1'b1, exp_q[i].d};
    end
    return r;
  endfunction
`endif

  // Monitor: at each falling edge, queue contents equal the DUT's stored entries.
  always @(negedge clk) begin
    if (!in_rst) begin
      chk("oReady", oReady, exp_q.size() < 2);
      chk("oWbValid", oWbValid, exp_q.size() != 0);
      chk("oFlagN", oFlagN, mdl_n);
      chk("oFlagZ", oFlagZ, mdl_z);
      if (exp_q.size() != 0) begin
        chk("head_data", oWbData, exp_q[0].d);
        chk("head_rd", oWbRd, exp_q[0].rd);
        chk("head_wren", oWbWrEn, exp_q[0].wr);
        last_d  = exp_q[0].d;
        last_rd = exp_q[0].rd;
      end else begin
        chk("idle_data", oWbData, last_d);
        chk("idle_rd", oWbRd, last_rd);
        chk("idle_wren", oWbWrEn, 1'b0);
      end
`ifdef WB_FWD_EN
      begin
        logic [DW:0] fa, fb;
        fa = fwd_model(iSrcA);
        fb = fwd_model(iSrcB);
        chk("fwd_hit_a", oFwdHitA, fa[DW]);
        chk("fwd_data_a", oFwdDataA, fa[DW-1:0]);
        chk("fwd_hit_b", oFwdHitB, fb[DW]);
        chk("fwd_data_b", oFwdDataB, fb[DW-1:0]);
      end
`endif
      if (exp_q.size() != 0 && iWbReady) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.sf) begin
          mdl_n = e.n;
          mdl_z = e.z;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] res, input logic n, input logic z,
                     input logic [AW-1:0] rd, input logic wr, input logic sf, input logic wbr);
    @(posedge clk);
    if (pend_v) exp_q.push_back(pend);
    pend_v = 1'b0;
    #1;
    iValid = v; iResult = res; iNEG = n; iZERO = z;
    iRd = rd; iWrEn = wr; iSetFlags = sf; iWbReady = wbr;
    if (v && exp_q.size() < 2) begin
      pend_v = 1'b1;
      pend = '{res, rd, wr && (rd != '0), sf, n, z};
    end
  endtask

  task automatic idle(input logic wbr, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, wbr);
  endtask

  task automatic do_reset();
    @(posedge clk);
    pend_v = 1'b0;
    #1;
    rst_n = 1'b0; in_rst = 1'b1;
    iValid = 1'b0; iWbReady = 1'b0;
    exp_q.delete();
    mdl_n = 1'b0; mdl_z = 1'b0; last_d = '0; last_rd = '0;
    #1;
    chk("rst_valid", oWbValid, 1'b0);
    chk("rst_ready", oReady, 1'b1);
    chk("rst_data", oWbData, '0);
    chk("rst_rd", oWbRd, '0);
    chk("rst_wren", oWbWrEn, 1'b0);
    chk("rst_n_flag", oFlagN, 1'b0);
    chk("rst_z_flag", oFlagZ, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single push with writeback ready: presented one cycle later.
    cyc(1'b1, 32'h5, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t1_valid", oWbValid, 1'b1);
    chk("t1_data", oWbData, 32'h5);
    chk("t1_rd", oWbRd, 5'd3);
    chk("t1_wren", oWbWrEn, 1'b1);
    idle(1'b1, 2);

    // Backpressure: third back-to-back push is held off.
    cyc(1'b1, 32'h11, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'h33, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t2_full_ready", oReady, 1'b0);
    idle(1'b1, 4);

    // Only flag-setting entries update N/Z.
    cyc(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 32'h0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 3);
    chk("t3_flag_n", oFlagN, 1'b1);
    chk("t3_flag_z", oFlagZ, 1'b0);

    // Write to register 0 is suppressed; then reset with two entries held.
    cyc(1'b1, 32'h1234, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t4_r0_valid", oWbValid, 1'b1);
    chk("t4_r0_data", oWbData, 32'h1234);
    chk("t4_r0_wren", oWbWrEn, 1'b0);
    cyc(1'b1, 32'h99, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1);
    do_reset();

`ifdef WB_FWD_EN
    iSrcA = 5'd7; iSrcB = 5'd0;
    cyc(1'b1, 32'hA, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t5_hit_a", oFwdHitA, 1'b1);
    chk("t5_data_a", oFwdDataA, 32'hB);
    chk("t5_hit_b", oFwdHitB, 1'b0);
    idle(1'b1, 3);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] res;
      res = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
`ifdef WB_FWD_EN
      iSrcA = AW'($urandom_range(0, 7));
      iSrcB = AW'($urandom_range(0, 7));
`endif
      if (i == 1500) do_reset();
      cyc($urandom_range(0, 3) != 0, res, res[DW-1], res == '0,
          AW'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
          $urandom_range(0, 2) != 0);
    end
    idle(1'b1, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
